pwm_output_ctrl: RTL and testbench
==================================

# pwm_output_ctrl

Output stage directly downstream of the SPI register file: consumes the five configuration registers (output enables, PWM enables, duty cycle) and drives the 16 chip outputs. Each output is held low, driven constant high, or driven by a shared 8-bit PWM waveform. The block generates its own prescaled PWM timebase. The duty value is double-buffered so that a register write landing mid-period never produces a truncated or glitched pulse.

## Interface
- PRESCALE, default 12: clk cycles per PWM count step, ≥1. Period is 256·PRESCALE clk cycles (about 3.26 kHz at 10 MHz).
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, outputs 7..0
- en_reg_out_15_8  input  8  output enable, outputs 15..8
- en_reg_pwm_7_0  input  8  PWM select, outputs 7..0
- en_reg_pwm_15_8  input  8  PWM select, outputs 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00 = 0 %, 0xFF = 100 %
- pwm_out  output  16  registered channel outputs
- period_start  output  1  one-clk pulse on the first cycle of each PWM period

## Operation
- Prescaler `pre` counts 0..PRESCALE-1 and wraps to 0.
  - `tick` = (pre == PRESCALE-1).
  - For PRESCALE=1, `tick` is constantly 1.
- PWM counter `cnt` (8 bit) increments on `tick` and wraps 255→0.
- Wrap event = `tick` && cnt == 255. On a wrap event:
  - `duty_sh` ← pwm_duty_cycle.
  - `period_start` is set for the next cycle, the cycle in which cnt==0 and pre==0.
- `pwm_raw` = (duty_sh == 0xFF) ? 1 : (cnt < duty_sh).
- Per channel i: en_out[i]=0 → 0; en_out[i]=1, en_pwm[i]=0 → 1; en_out[i]=1, en_pwm[i]=1 → `pwm_raw`.
- Enable registers take effect immediately, with no shadowing. Only duty is period-synchronous.
- No internal state machine beyond the two counters and the shadow register.

## Timing
- Reset values: pwm_out=0, period_start=0, pre=0, cnt=0, duty_sh=0.
- Latency: pwm_out at cycle t+1 reflects inputs, cnt and duty_sh at cycle t.
- High time per period = duty_sh·PRESCALE clk cycles. 0xFF gives all 256·PRESCALE cycles, not 255·PRESCALE.
- First period after reset release:
  - duty_sh is 0, so PWM channels are low for the whole period.
  - First period_start occurs 256·PRESCALE cycles after the first active clock edge.
- Duty written mid-period: the current period completes with the old value; the new value applies from the next period_start.
- Duty written in the same cycle as a wrap event: the new value is captured.
- Several duty writes within one period: only the value present at the wrap event is used.
- Reset asserted mid-operation: all state and outputs clear immediately and asynchronously. The timebase restarts from 0 on release.

## Structure
- Shared package holds:
  - PWM_CNT_W = 8
  - DUTY_FULL = 8'hFF
  - NUM_CH = 16
  - DEFAULT_PRESCALE = 12
- Sub-module pwm_timebase:
  - Contains the prescaler, cnt and the wrap/period_start logic.
  - Outputs cnt, wrap and period_start.
- The top level holds the duty shadow register, the compare, and the channel mux and output register.

## Test plan
All scenarios use PRESCALE=4, so the period is 1024 clk cycles.
- Reset hold: rst_n=0 with random inputs → pwm_out=0 and period_start=0 throughout. After release, first period_start occurs at cycle 1024.
- Static enable: en_out=0x0001, en_pwm=0x0000 → pwm_out=0x0001 one cycle after the input is applied; all other bits stay 0.
- Half duty: en_out=en_pwm=0x8001, duty=0x80 → after the first period_start, bits 0 and 15 are high for 512 consecutive cycles, then low for 512, repeating.
- Extremes:
  - duty=0x00 → PWM channels never high over 2 periods.
  - duty=0xFF → PWM channels constantly high over 2 periods with no one-cycle dip at the wrap.
- Mid-period update: duty=0x40, then change to 0xC0 at cnt=100 → the current period keeps 256 high cycles; the next period has 768.
- Reset mid-period: assert rst_n=0 at cnt=150 → pwm_out goes to 0 before the next clk edge. After release, the timebase restarts and the next period_start comes 1024 cycles later.

Source files
------------

// File: rtl/pwm_output_ctrl_pkg.sv
// Shared constants, payload types and helpers for the PWM output stage.
package pwm_output_ctrl_pkg;

  localparam int unsigned PWM_CNT_W        = 8;
  localparam logic [7:0]  DUTY_FULL        = 8'hFF;
  localparam int unsigned NUM_CH           = 16;
  localparam int unsigned DEFAULT_PRESCALE = 12;

  // Per-channel enable configuration, gathered from the byte-wide registers.
  typedef struct packed {
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
  } ch_cfg_t;

  // Channel select: disabled -> 0, enabled static -> 1, enabled PWM -> waveform.
  function automatic logic [NUM_CH-1:0] chan_mux(input ch_cfg_t cfg, input logic pwm_raw);
    return cfg.en_out & (~cfg.en_pwm | {NUM_CH{pwm_raw}});
  endfunction

endpackage

// File: rtl/pwm_output_ctrl_if.sv
// Register-file to output-stage bundle.
//   master: register file side (drives enables and duty, observes outputs)
//   slave : output stage side (consumes configuration, drives pwm_out/period_start)
interface pwm_output_ctrl_if;
  import pwm_output_ctrl_pkg::*;

  logic [7:0]        en_reg_out_7_0;
  logic [7:0]        en_reg_out_15_8;
  logic [7:0]        en_reg_pwm_7_0;
  logic [7:0]        en_reg_pwm_15_8;
  logic [7:0]        pwm_duty_cycle;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  pwm_out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output pwm_out, period_start
  );

endinterface

// File: rtl/pwm_output_ctrl_timebase.sv
// PWM timebase: prescaler, 8-bit period counter and period-boundary events.
//   clk, rst_n   : clock, async active-low reset
//   cnt          : current PWM count (registered)
//   wrap_c       : last prescaled step of the period (combinational)
//   period_start : one-cycle pulse on the first cycle of each period (registered)
module pwm_output_ctrl_timebase
  import pwm_output_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] cnt,
  output logic                 wrap_c,
  output logic                 period_start
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre_q;
  logic             tick_c;

  // With PRESCALE=1 pre_q is pinned at 0, so tick_c is constantly 1.
  assign tick_c = (pre_q == PRE_W'(PRESCALE - 1));
  assign wrap_c = tick_c && (cnt == {PWM_CNT_W{1'b1}});

  // Prescaler, count and period-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      pre_q        <= tick_c ? '0 : pre_q + PRE_W'(1);
      period_start <= wrap_c;
      if (tick_c) begin
        cnt <= cnt + PWM_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_output_ctrl.sv
// PWM output stage: 16 channels, each held low, driven high, or driven by
// a shared PWM waveform whose duty is shadowed at period boundaries.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of pwm_output_ctrl_if (enables, duty in;
//                pwm_out, period_start out)
module pwm_output_ctrl
  import pwm_output_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_output_ctrl_if.slave  bus
);

  logic [PWM_CNT_W-1:0] cnt;
  logic                 wrap_c;
  logic                 period_start;
  logic [PWM_CNT_W-1:0] duty_sh;
  logic                 pwm_raw_c;
  ch_cfg_t              cfg_c;
  logic [NUM_CH-1:0]    pwm_out_q;

  pwm_output_ctrl_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt          (cnt),
    .wrap_c       (wrap_c),
    .period_start (period_start)
  );

  // Enables are used live; only the duty is period-synchronous.
  assign cfg_c.en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign cfg_c.en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // Full-scale duty is forced high so 0xFF covers all 256 steps.
  assign pwm_raw_c = (duty_sh == DUTY_FULL) ? 1'b1 : (cnt < duty_sh);

  // Duty shadow (loaded only at the wrap) and channel output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh   <= '0;
      pwm_out_q <= '0;
    end else begin
      if (wrap_c) begin
        duty_sh <= bus.pwm_duty_cycle;
      end
      pwm_out_q <= chan_mux(cfg_c, pwm_raw_c);
    end
  end

  assign bus.pwm_out      = pwm_out_q;
  assign bus.period_start = period_start;

endmodule

// File: tb/tb_pwm_output_ctrl.sv
// Directed self-checking bench for pwm_output_ctrl with PRESCALE=4 (1024-cycle period).
module tb_pwm_output_ctrl;

  localparam int PERIOD = 1024;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pwm_output_ctrl_if bus ();

  pwm_output_ctrl #(
    .PRESCALE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_en(input logic [15:0] en_out, input logic [15:0] en_pwm);
    bus.en_reg_out_7_0  = en_out[7:0];
    bus.en_reg_out_15_8 = en_out[15:8];
    bus.en_reg_pwm_7_0  = en_pwm[7:0];
    bus.en_reg_pwm_15_8 = en_pwm[15:8];
  endtask

  // Waits (bounded) for the next period_start; k = negedges elapsed, -1 on timeout.
  task automatic wait_ps(output int k, output int nz);
    k  = -1;
    nz = 0;
    for (int i = 1; i <= PERIOD + 100; i++) begin
      @(negedge clk);
      if (bus.pwm_out != 16'h0) nz++;
      if (bus.period_start) begin
        k = i;
        break;
      end
    end
  endtask

  // Observes one full period starting at a period_start negedge. Highs must be
  // a contiguous run at samples 1..exp_hi; an optional duty write at wr_idx.
  task automatic check_period(input string tag, input logic [15:0] mask, input int exp_hi,
                              input int wr_idx, input logic [7:0] wr_val);
    int hi, last_hi, bad, ps_idx;
    hi = 0; last_hi = 0; bad = 0; ps_idx = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (bus.pwm_out == mask) begin
        hi++;
        last_hi = i;
      end else if (bus.pwm_out != 16'h0) begin
        bad++;
      end
      if (bus.period_start && ps_idx == 0) ps_idx = i;
      if (i == wr_idx) bus.pwm_duty_cycle = wr_val;
    end
    check({tag, "_high_cycles"}, hi, exp_hi);
    check({tag, "_last_high"}, last_hi, exp_hi);
    check({tag, "_stray_bits"}, bad, 0);
    check({tag, "_next_ps"}, ps_idx, PERIOD);
  endtask

  initial begin
    int k, nz, bad;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_en(16'h0, 16'h0);
    bus.pwm_duty_cycle = 8'h00;

    // Reset hold with random configuration.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_en(16'($urandom), 16'($urandom));
      bus.pwm_duty_cycle = 8'($urandom);
      #1;
      check("rst_hold_pwm_out", int'(bus.pwm_out), 0);
      check("rst_hold_period_start", int'(bus.period_start), 0);
    end

    // Release; first period has duty_sh=0 so PWM channels stay low.
    @(negedge clk);
    set_en(16'h8001, 16'h8001);
    bus.pwm_duty_cycle = 8'h80;
    rst_n = 1'b1;
    wait_ps(k, nz);
    check("first_ps_cycle", k, PERIOD);
    check("first_period_low", nz, 0);

    // Half duty, two periods; duty 0 written during the second one.
    check_period("half_p1", 16'h8001, 512, 0, 8'h00);
    bus.pwm_duty_cycle = 8'h00;
    check_period("half_p2", 16'h8001, 512, 0, 8'h00);

    // Zero duty, two periods; 0xFF queued during the second.
    check_period("zero_p1", 16'h8001, 0, 0, 8'h00);
    bus.pwm_duty_cycle = 8'hFF;
    check_period("zero_p2", 16'h8001, 0, 0, 8'h00);

    // Full duty across the wrap seam; several writes, last one (0x40) wins.
    check_period("full_p1", 16'h8001, PERIOD, 0, 8'h00);
    bus.pwm_duty_cycle = 8'h10;
    check_period("full_p2", 16'h8001, PERIOD, 500, 8'h40);

    // 0x40 with 0xC0 written at cnt=100; then a write in the wrap cycle.
    check_period("mid_old", 16'h8001, 256, 400, 8'hC0);
    check_period("mid_new", 16'h8001, 768, 1023, 8'h20);
    check_period("wrap_write", 16'h8001, 128, 0, 8'h00);

    // Static enable on channel 0 only, then reset at cnt=150.
    set_en(16'h0001, 16'h0000);
    @(negedge clk);
    check("static_en_first", int'(bus.pwm_out), 16'h0001);
    bad = 0;
    for (int i = 2; i <= 600; i++) begin
      @(negedge clk);
      if (bus.pwm_out != 16'h0001) bad++;
    end
    check("static_en_hold", bad, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm_out", int'(bus.pwm_out), 0);
    check("async_rst_period_start", int'(bus.period_start), 0);
    repeat (3) @(negedge clk);
    check("rst_held_pwm_out", int'(bus.pwm_out), 0);
    rst_n = 1'b1;
    wait_ps(k, nz);
    check("restart_ps_cycle", k, PERIOD);
    @(negedge clk);
    check("static_after_restart", int'(bus.pwm_out), 16'h0001);
    check("ps_single_cycle", int'(bus.period_start), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
